// File: rtl/mpu_host_cmd.sv
// Host-side command transmitter for the MPU: serialises one command descriptor into MPU interface beats.
// Optional watchdog on WAIT_RUN / LD_DATA stalls: define MPU_HOST_TIMEOUT_EN.
module mpu_host_cmd #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int NUM_TPU        = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Cmd_Valid,
    output logic                  O_Cmd_Ready,
    input  logic [2:0]            I_Cmd_Op,
    input  logic [DATA_WIDTH-1:0] I_Cmd_Id,
    input  logic [DATA_WIDTH-1:0] I_Cmd_Stride,
    input  logic [DATA_WIDTH-1:0] I_Cmd_Base,
    input  logic [LEN_WIDTH-1:0]  I_Cmd_Len,
    input  logic [NUM_TPU-1:0]    I_Cmd_Mask,
    input  logic                  I_St_Valid,
    input  logic [DATA_WIDTH-1:0] I_St_Data,
    output logic                  O_St_Ready,
    output logic                  O_Ld_Valid,
    output logic [DATA_WIDTH-1:0] O_Ld_Data,
    output logic                  O_Req_IF,
    output logic                  O_Data_IF_V,
    output logic [DATA_WIDTH-1:0] O_Data_IF,
    output logic                  O_Last_IF,
    input  logic                  I_Req_IF,
    input  logic                  I_Data_IF_V,
    input  logic [DATA_WIDTH-1:0] I_Data_IF,
    input  logic [3:0]            I_State,
    output logic                  O_Done,
    output logic                  O_Err,
    output logic                  O_Busy
);

    localparam logic [2:0] OP_RUN   = 3'd0;
    localparam logic [2:0] OP_STPRG = 3'd1;
    localparam logic [2:0] OP_STDAT = 3'd2;
    localparam logic [2:0] OP_LDDAT = 3'd3;
    localparam logic [2:0] OP_STOP  = 3'd4;
    localparam logic [2:0] OP_SETEN = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CMD, S_ID, S_STRIDE, S_BASE, S_MASK,
        S_ST_DATA, S_LD_DATA, S_WAIT_RUN, S_DONE, S_ERR
    } state_t;

    state_t                r_state;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_id;
    logic [DATA_WIDTH-1:0] r_stride;
    logic [DATA_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [NUM_TPU-1:0]    r_mask;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_ill_err;
    logic                  r_ld_valid;
    logic [DATA_WIDTH-1:0] r_ld_data;

    logic w_accept;
    logic w_st_beat;
    logic w_ld_word;
    logic w_last;
    logic w_timeout;
    logic w_unused;

    assign w_accept  = I_Cmd_Valid && (r_state == S_IDLE);
    // NoThMem takes priority over a pending store word so nothing is consumed on abort
    assign w_st_beat = (r_state == S_ST_DATA) && I_St_Valid && !I_State[3];
    assign w_ld_word = (r_state == S_LD_DATA) && I_Data_IF_V && I_Req_IF;
    assign w_last    = (r_cnt == r_len - LEN_WIDTH'(1));
    assign w_unused  = &{1'b0, I_State[2], I_State[0], TIMEOUT_CYCLES[0]};

`ifdef MPU_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;
    logic            w_stall;

    assign w_stall   = ((r_state == S_WAIT_RUN) && !I_State[1] && !I_State[3]) ||
                       ((r_state == S_LD_DATA) && !w_ld_word);
    assign w_timeout = w_stall && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !w_stall) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op     <= I_Cmd_Op;
            r_id     <= I_Cmd_Id;
            r_stride <= I_Cmd_Stride;
            r_base   <= I_Cmd_Base;
            r_len    <= I_Cmd_Len;
            r_mask   <= I_Cmd_Mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ill_err  <= 1'b0;
            r_ld_valid <= 1'b0;
            r_ld_data  <= '0;
        end else begin
            r_ill_err  <= 1'b0;
            r_ld_valid <= w_ld_word;
            if (w_ld_word) begin
                r_ld_data <= I_Data_IF;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (I_Cmd_Op > OP_SETEN) begin
                            r_ill_err <= 1'b1;
                        end else begin
                            r_state <= S_PRE;
                        end
                    end
                end
                S_PRE: r_state <= S_CMD;
                S_CMD: begin
                    case (r_op)
                        OP_RUN, OP_STDAT, OP_LDDAT: r_state <= S_ID;
                        OP_STPRG: r_state <= (r_len == '0) ? S_DONE : S_ST_DATA;
                        OP_SETEN: r_state <= S_MASK;
                        default:  r_state <= S_DONE;
                    endcase
                end
                S_ID:     r_state <= (r_op == OP_RUN) ? S_WAIT_RUN : S_STRIDE;
                S_STRIDE: r_state <= S_BASE;
                S_BASE: begin
                    if (r_len == '0) begin
                        r_state <= S_DONE;
                    end else if (r_op == OP_STDAT) begin
                        r_state <= S_ST_DATA;
                    end else begin
                        r_state <= S_LD_DATA;
                    end
                end
                S_MASK: r_state <= S_DONE;
                S_ST_DATA: begin
                    if (I_State[3]) begin
                        r_state <= S_ERR;
                    end else if (w_st_beat) begin
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LD_DATA: begin
                    if (w_ld_word) begin
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_WAIT_RUN: begin
                    if (I_State[1]) begin
                        r_state <= S_DONE;
                    end else if (I_State[3] || w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        O_Req_IF  = 1'b0;
        O_Data_IF = '0;
        case (r_state)
            S_PRE: O_Req_IF = 1'b1;
            S_CMD: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = DATA_WIDTH'(1) << r_op;
            end
            S_ID: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = r_id;
            end
            S_STRIDE: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = r_stride;
            end
            S_BASE: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = r_base;
            end
            S_MASK: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = DATA_WIDTH'(r_mask);
            end
            S_ST_DATA: begin
                O_Req_IF  = w_st_beat;
                O_Data_IF = w_st_beat ? I_St_Data : '0;
            end
            default: ;
        endcase
    end

    assign O_Data_IF_V = O_Req_IF;
    assign O_Last_IF   = w_st_beat && w_last;
    assign O_St_Ready  = w_st_beat;
    assign O_Ld_Valid  = r_ld_valid;
    assign O_Ld_Data   = r_ld_data;
    assign O_Cmd_Ready = (r_state == S_IDLE);
    assign O_Busy      = (r_state != S_IDLE);
    assign O_Done      = (r_state == S_DONE);
    assign O_Err       = (r_state == S_ERR) || r_ill_err;

endmodule
